// File: rtl/hamming_pkg.sv
// rtl/hamming_pkg.sv - Hamming(7,4) widths, codeword bit map and pure helpers
package hamming_pkg;

    localparam int DATA_W = 4;
    localparam int CODE_W = 7;
    localparam int SYN_W  = 3;

    // Codeword position p lives at bit index p-1
    localparam int P1 = 0;
    localparam int P2 = 1;
    localparam int D0 = 2;
    localparam int P4 = 3;
    localparam int D1 = 4;
    localparam int D2 = 5;
    localparam int D3 = 6;

    function automatic logic [CODE_W-1:0] ham_encode(input logic [DATA_W-1:0] d);
        logic [CODE_W-1:0] c;
        c     = '0;
        c[D0] = d[0];
        c[D1] = d[1];
        c[D2] = d[2];
        c[D3] = d[3];
        c[P1] = d[0] ^ d[1] ^ d[3];
        c[P2] = d[0] ^ d[2] ^ d[3];
        c[P4] = d[1] ^ d[2] ^ d[3];
        return c;
    endfunction

    function automatic logic [SYN_W-1:0] ham_syndrome(input logic [CODE_W-1:0] c);
        logic [SYN_W-1:0] s;
        s[0] = c[0] ^ c[2] ^ c[4] ^ c[6];
        s[1] = c[1] ^ c[2] ^ c[5] ^ c[6];
        s[2] = c[3] ^ c[4] ^ c[5] ^ c[6];
        return s;
    endfunction

endpackage

// File: rtl/hamming_codec_if.sv
// rtl/hamming_codec_if.sv - encoder/decoder stream and status signals of the codec
interface hamming_codec_if;

    logic                                  enc_valid_in;
    logic [hamming_pkg::DATA_W-1:0]        data_in;
    logic                                  enc_valid_out;
    logic [hamming_pkg::CODE_W-1:0]        ham_encoded;
    logic                                  dec_valid_in;
    logic [hamming_pkg::CODE_W-1:0]        ham_data;
    logic                                  dec_valid_out;
    logic [hamming_pkg::DATA_W-1:0]        data_out;
    logic [hamming_pkg::SYN_W-1:0]         error_position;
    logic                                  is_error;
    logic [15:0]                           corr_count;
    logic                                  clr_count;

    modport master (
        output enc_valid_in, data_in, dec_valid_in, ham_data, clr_count,
        input  enc_valid_out, ham_encoded, dec_valid_out, data_out,
               error_position, is_error, corr_count
    );

    modport slave (
        input  enc_valid_in, data_in, dec_valid_in, ham_data, clr_count,
        output enc_valid_out, ham_encoded, dec_valid_out, data_out,
               error_position, is_error, corr_count
    );

endinterface

// File: rtl/hamming74_core.sv
// rtl/hamming74_core.sv - combinational Hamming(7,4) encode, syndrome, correct and extract
module hamming74_core
    import hamming_pkg::*;
(
    input  logic [DATA_W-1:0] enc_data,
    output logic [CODE_W-1:0] enc_code,
    input  logic [CODE_W-1:0] rx_code,
    output logic [DATA_W-1:0] dec_data,
    output logic [SYN_W-1:0]  syndrome
);

    logic [CODE_W-1:0] flip_mask;
    logic [CODE_W-1:0] corrected;

    assign enc_code = ham_encode(enc_data);
    assign syndrome = ham_syndrome(rx_code);

    // A nonzero syndrome names the flipped position directly (1-based)
    assign flip_mask = (syndrome == '0) ? '0
                     : (CODE_W'(1) << (syndrome - SYN_W'(1)));
    assign corrected = rx_code ^ flip_mask;
    assign dec_data  = {corrected[D3], corrected[D2], corrected[D1], corrected[D0]};

endmodule

// File: rtl/hamming_codec.sv
// rtl/hamming_codec.sv - registered Hamming(7,4) encoder/decoder with corrected-word counter
module hamming_codec
    import hamming_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    hamming_codec_if.slave  bus
);

    logic [CODE_W-1:0] enc_code;
    logic [DATA_W-1:0] dec_data;
    logic [SYN_W-1:0]  syndrome;

    logic              enc_valid_q;
    logic [CODE_W-1:0] ham_encoded_q;
    logic              dec_valid_q;
    logic [DATA_W-1:0] data_out_q;
    logic [SYN_W-1:0]  error_position_q;
    logic [15:0]       corr_count_q;

    hamming74_core u_core (
        .enc_data (bus.data_in),
        .enc_code (enc_code),
        .rx_code  (bus.ham_data),
        .dec_data (dec_data),
        .syndrome (syndrome)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            enc_valid_q      <= 1'b0;
            ham_encoded_q    <= '0;
            dec_valid_q      <= 1'b0;
            data_out_q       <= '0;
            error_position_q <= '0;
        end else begin
            enc_valid_q <= bus.enc_valid_in;
            dec_valid_q <= bus.dec_valid_in;
            if (bus.enc_valid_in) begin
                ham_encoded_q <= enc_code;
            end
            if (bus.dec_valid_in) begin
                data_out_q       <= dec_data;
                error_position_q <= syndrome;
            end
        end
    end

    // Clear beats a same-cycle increment; the count sticks at all-ones
    always_ff @(posedge clk) begin
        if (rst || bus.clr_count) begin
            corr_count_q <= '0;
        end else if (bus.dec_valid_in && (syndrome != '0) && (corr_count_q != 16'hFFFF)) begin
            corr_count_q <= corr_count_q + 16'd1;
        end
    end

    assign bus.enc_valid_out  = enc_valid_q;
    assign bus.ham_encoded    = ham_encoded_q;
    assign bus.dec_valid_out  = dec_valid_q;
    assign bus.data_out       = data_out_q;
    assign bus.error_position = error_position_q;
    assign bus.is_error       = (error_position_q != '0);
    assign bus.corr_count     = corr_count_q;

endmodule

// File: tb/tb_hamming_codec.sv
// tb/tb_hamming_codec.sv - directed self-checking bench for hamming_codec
module tb_hamming_codec;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    int   exp_cnt;

    localparam logic [6:0] CW [16] = '{
        7'h00, 7'h07, 7'h19, 7'h1E, 7'h2A, 7'h2D, 7'h33, 7'h34,
        7'h4B, 7'h4C, 7'h52, 7'h55, 7'h61, 7'h66, 7'h78, 7'h7F
    };

    hamming_codec_if bus ();

    hamming_codec dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic ev, input logic [3:0] nib, input logic dv,
                        input logic [6:0] w, input logic clr, input logic r);
        bus.enc_valid_in = ev;
        bus.data_in      = nib;
        bus.dec_valid_in = dv;
        bus.ham_data     = w;
        bus.clr_count    = clr;
        rst              = r;
        @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, " enc_valid_out"}, bus.enc_valid_out, 0);
        check({tag, " ham_encoded"}, bus.ham_encoded, 0);
        check({tag, " dec_valid_out"}, bus.dec_valid_out, 0);
        check({tag, " data_out"}, bus.data_out, 0);
        check({tag, " error_position"}, bus.error_position, 0);
        check({tag, " is_error"}, bus.is_error, 0);
        check({tag, " corr_count"}, bus.corr_count, 0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        exp_cnt  = 0;

        step(1, 4'hF, 1, 7'h01, 0, 1);
        step(1, 4'hF, 1, 7'h01, 0, 1);
        check_zero("reset");

        step(1, 4'b1011, 0, 7'h00, 0, 0);
        check("enc 1011 valid", bus.enc_valid_out, 1);
        check("enc 1011 code", bus.ham_encoded, 7'b1010101);
        check("enc idle dec_valid", bus.dec_valid_out, 0);

        step(0, 4'h0, 1, 7'b1010101, 0, 0);
        check("enc hold valid", bus.enc_valid_out, 0);
        check("enc hold code", bus.ham_encoded, 7'b1010101);
        check("clean valid", bus.dec_valid_out, 1);
        check("clean data", bus.data_out, 4'b1011);
        check("clean pos", bus.error_position, 0);
        check("clean is_error", bus.is_error, 0);
        check("clean count", bus.corr_count, 0);

        step(0, 4'h0, 1, 7'b1010101 ^ 7'b0000100, 0, 0);
        check("flip3 pos", bus.error_position, 3);
        check("flip3 is_error", bus.is_error, 1);
        check("flip3 data", bus.data_out, 4'b1011);
        check("flip3 count", bus.corr_count, 1);

        step(0, 4'h0, 1, 7'b1010101 ^ 7'b0100000, 0, 0);
        check("flip6 pos", bus.error_position, 6);
        check("flip6 data", bus.data_out, 4'b1011);
        check("flip6 count", bus.corr_count, 2);

        step(1, 4'b0110, 1, 7'b0110010, 0, 0);
        check("enc 0110 code", bus.ham_encoded, 7'b0110011);
        check("par1 pos", bus.error_position, 1);
        check("par1 is_error", bus.is_error, 1);
        check("par1 data", bus.data_out, 4'b0110);
        check("par1 count", bus.corr_count, 3);

        step(0, 4'h0, 0, 7'h7F, 0, 0);
        check("idle dec_valid", bus.dec_valid_out, 0);
        check("idle data hold", bus.data_out, 4'b0110);
        check("idle pos hold", bus.error_position, 1);
        check("idle count hold", bus.corr_count, 3);
        exp_cnt = 3;

        for (int n = 0; n < 16; n++) begin
            for (int k = 0; k < 7; k++) begin
                logic do_clr;
                logic do_rst;
                logic [6:0] w;
                do_clr = (n == 4 && k == 3);
                do_rst = (n == 9 && k == 2);
                w = CW[n];
                w[k] = ~w[k];
                step(1, 4'(n), 1, w, do_clr, do_rst);
                if (do_rst) begin
                    exp_cnt = 0;
                    check_zero($sformatf("midrst n%0d", n));
                end else begin
                    exp_cnt = do_clr ? 0 : exp_cnt + 1;
                    check($sformatf("exh enc n%0d", n), bus.ham_encoded, CW[n]);
                    check($sformatf("exh ev n%0d", n), bus.enc_valid_out, 1);
                    check($sformatf("exh data n%0d k%0d", n, k), bus.data_out, n);
                    check($sformatf("exh pos n%0d k%0d", n, k), bus.error_position, k + 1);
                    check($sformatf("exh err n%0d k%0d", n, k), bus.is_error, 1);
                    check($sformatf("exh cnt n%0d k%0d", n, k), bus.corr_count, exp_cnt);
                end
            end
        end

        force dut.corr_count_q = 16'hFFFE;
        #1;
        release dut.corr_count_q;
        check("sat preload", bus.corr_count, 16'hFFFE);
        step(0, 4'h0, 1, 7'h01, 0, 0);
        check("sat reach", bus.corr_count, 16'hFFFF);
        step(0, 4'h0, 1, 7'h02, 0, 0);
        check("sat hold", bus.corr_count, 16'hFFFF);
        step(0, 4'h0, 1, 7'h55, 0, 0);
        check("sat clean", bus.corr_count, 16'hFFFF);
        step(0, 4'h0, 1, 7'h04, 1, 0);
        check("sat clr", bus.corr_count, 0);
        check("sat clr pos", bus.error_position, 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
